// File: rtl/arcade_input_ctrl_if.sv
// Player/coin signal bundle between the hps_io side and the input conditioning stage.
// ps2_key events are toggle-based (bit 64 flips once per event); there is no valid/ready
// handshake, every other signal is a level sampled each clk_sys cycle.
interface arcade_input_ctrl_if;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        orient_horz;
  logic        autofire_en;
  logic        coin;
  logic        start1;
  logic        start2;
  logic        left1;
  logic        right1;
  logic        fire1;
  logic        left2;
  logic        right2;
  logic        fire2;
  logic [1:0]  coin_state;

  modport master (
    output ps2_key, joystick_0, joystick_1, orient_horz, autofire_en,
    input  coin, start1, start2, left1, right1, fire1, left2, right2, fire2, coin_state
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, orient_horz, autofire_en,
    output coin, start1, start2, left1, right1, fire1, left2, right2, fire2, coin_state
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 keys and joysticks into registered galaga inputs, with orientation remap,
// coin pulse shaping/holdoff and per-player autofire.
module arcade_input_ctrl #(
  parameter int COIN_PULSE_CYC   = 1800000,
  parameter int COIN_HOLDOFF_CYC = 1800000,
  parameter int AUTOFIRE_HALF    = 900000
) (
  input logic                clk_sys,
  input logic                reset,
  arcade_input_ctrl_if.slave io
);
  localparam int COIN_MAX = (COIN_PULSE_CYC > COIN_HOLDOFF_CYC) ? COIN_PULSE_CYC : COIN_HOLDOFF_CYC;
  localparam int CW = $clog2(COIN_MAX) + 1;
  localparam int AW = $clog2(AUTOFIRE_HALF) + 1;

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_PULSE = 2'd1, C_HOLD = 2'd2} coin_state_e;

  // keys bit order: 0 up, 1 down, 2 left, 3 right, 4 fire, 5 start1, 6 start2, 7 coin
  logic [7:0]    keys_q, keys_d;
  logic          key_tgl_q;
  logic          key_event, key_pressed;

  coin_state_e   coin_state_q, coin_state_d;
  logic [CW-1:0] coin_cnt_q, coin_cnt_d;
  logic          coin_q, coin_d;
  logic          coin_prev_q, raw_coin, coin_rise;

  logic [1:0]    fire_raw, fire_q, fire_d, fire_prev_q;
  logic [AW-1:0] af_cnt_q [2];
  logic [AW-1:0] af_cnt_d [2];
  logic          af_en_prev_q;

  logic [1:0]    left_src, right_src, left_d, right_d, left_q, right_q;
  logic          start1_d, start2_d, start1_q, start2_q;

  logic          unused_bits;
  assign unused_bits = ^{io.joystick_0[15:8], io.joystick_0[5],
                         io.joystick_1[15:8], io.joystick_1[5], io.ps2_key[23:16]};

  always_comb begin
    keys_d      = keys_q;
    key_event   = (io.ps2_key[64] != key_tgl_q);
    key_pressed = (io.ps2_key[15:8] != 8'hF0);
    if (key_event && (io.ps2_key[63:24] == 40'd0)) begin
      case (io.ps2_key[7:0])
        8'h75:   keys_d[0] = key_pressed;
        8'h72:   keys_d[1] = key_pressed;
        8'h6B:   keys_d[2] = key_pressed;
        8'h74:   keys_d[3] = key_pressed;
        8'h29:   keys_d[4] = key_pressed;
        8'h05:   keys_d[5] = key_pressed;
        8'h06:   keys_d[6] = key_pressed;
        8'h04:   keys_d[7] = key_pressed;
        default: keys_d    = keys_q;
      endcase
    end
  end

  // Rotated screen maps the joystick's down/up onto left/right.
  always_comb begin
    left_src[0]  = io.orient_horz ? (keys_q[1] | io.joystick_0[2]) : (keys_q[2] | io.joystick_0[1]);
    right_src[0] = io.orient_horz ? (keys_q[0] | io.joystick_0[3]) : (keys_q[3] | io.joystick_0[0]);
    left_src[1]  = io.orient_horz ? io.joystick_1[2] : io.joystick_1[1];
    right_src[1] = io.orient_horz ? io.joystick_1[3] : io.joystick_1[0];
    left_d       = left_src & ~right_src;
    right_d      = right_src & ~left_src;
    start1_d     = keys_q[5] | io.joystick_0[6];
    start2_d     = keys_q[6] | io.joystick_1[6];
    fire_raw[0]  = keys_q[4] | io.joystick_0[4];
    fire_raw[1]  = io.joystick_1[4];
  end

  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    coin_d       = coin_q;
    raw_coin     = keys_q[7] | io.joystick_0[7] | io.joystick_1[7];
    coin_rise    = raw_coin & ~coin_prev_q;
    case (coin_state_q)
      C_IDLE: begin
        if (coin_rise) begin
          coin_state_d = C_PULSE;
          coin_d       = 1'b1;
          coin_cnt_d   = CW'(COIN_PULSE_CYC - 1);
        end
      end
      C_PULSE: begin
        if (coin_cnt_q == '0) begin
          coin_state_d = C_HOLD;
          coin_d       = 1'b0;
          coin_cnt_d   = CW'(COIN_HOLDOFF_CYC - 1);
        end else begin
          coin_cnt_d = coin_cnt_q - 1'b1;
        end
      end
      C_HOLD: begin
        if (coin_cnt_q == '0) coin_state_d = C_IDLE;
        else                  coin_cnt_d   = coin_cnt_q - 1'b1;
      end
      default: begin
        coin_state_d = C_IDLE;
        coin_d       = 1'b0;
        coin_cnt_d   = '0;
      end
    endcase
  end

  // A fresh press, or autofire just being enabled, restarts the phase with fire high.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fire_d[p]   = fire_q[p];
      af_cnt_d[p] = af_cnt_q[p];
      if (!io.autofire_en) begin
        fire_d[p]   = fire_raw[p];
        af_cnt_d[p] = '0;
      end else if (!fire_raw[p]) begin
        fire_d[p]   = 1'b0;
        af_cnt_d[p] = '0;
      end else if (!fire_prev_q[p] || !af_en_prev_q) begin
        fire_d[p]   = 1'b1;
        af_cnt_d[p] = '0;
      end else if (af_cnt_q[p] == AW'(AUTOFIRE_HALF - 1)) begin
        fire_d[p]   = ~fire_q[p];
        af_cnt_d[p] = '0;
      end else begin
        af_cnt_d[p] = af_cnt_q[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      keys_q       <= '0;
      key_tgl_q    <= io.ps2_key[64];
      coin_state_q <= C_IDLE;
      coin_cnt_q   <= '0;
      coin_q       <= 1'b0;
      coin_prev_q  <= raw_coin;
      fire_q       <= '0;
      fire_prev_q  <= '0;
      af_cnt_q     <= '{default: '0};
      af_en_prev_q <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      key_tgl_q    <= io.ps2_key[64];
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_q       <= coin_d;
      coin_prev_q  <= raw_coin;
      fire_q       <= fire_d;
      fire_prev_q  <= fire_raw;
      af_cnt_q     <= af_cnt_d;
      af_en_prev_q <= io.autofire_en;
      left_q       <= left_d;
      right_q      <= right_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
    end
  end

  assign io.coin       = coin_q;
  assign io.start1     = start1_q;
  assign io.start2     = start2_q;
  assign io.left1      = left_q[0];
  assign io.right1     = right_q[0];
  assign io.fire1      = fire_q[0];
  assign io.left2      = left_q[1];
  assign io.right2     = right_q[1];
  assign io.fire2      = fire_q[1];
  assign io.coin_state = coin_state_q;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus random traffic, every cycle
// compared against a cycle-level behavioural model.
module tb_arcade_input_ctrl;
  localparam int P    = 4;
  localparam int H    = 6;
  localparam int HALF = 3;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl_if io ();

  arcade_input_ctrl #(
    .COIN_PULSE_CYC(P), .COIN_HOLDOFF_CYC(H), .AUTOFIRE_HALF(HALF)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .io     (io.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  // Reference model state
  bit key_st [256];
  bit m_tgl;
  bit m_coin_prev;
  int m_age = -1;
  int m_run [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] j0, j1;
    logic [8:0]  e;
    bit raw_c, l_eff, r_eff;
    bit up [2], dn [2], lf [2], rt [2], fr [2], st [2], lo [2], ro [2], fo [2];
    j0    = io.joystick_0;
    j1    = io.joystick_1;
    raw_c = key_st[8'h04] | j0[7] | j1[7];
    if (reset) begin
      foreach (key_st[i]) key_st[i] = 1'b0;
      m_tgl       = io.ps2_key[64];
      m_coin_prev = raw_c;
      m_age       = -1;
      m_run[0]    = 0;
      m_run[1]    = 0;
      e           = '0;
    end else begin
      if (m_age < 0) begin
        if (raw_c && !m_coin_prev) m_age = 0;
      end else begin
        m_age++;
        if (m_age >= P + H) m_age = -1;
      end
      m_coin_prev = raw_c;
      up[0] = key_st[8'h75] | j0[3];  dn[0] = key_st[8'h72] | j0[2];
      lf[0] = key_st[8'h6B] | j0[1];  rt[0] = key_st[8'h74] | j0[0];
      fr[0] = key_st[8'h29] | j0[4];  st[0] = key_st[8'h05] | j0[6];
      up[1] = j1[3];  dn[1] = j1[2];  lf[1] = j1[1];  rt[1] = j1[0];
      fr[1] = j1[4];  st[1] = key_st[8'h06] | j1[6];
      for (int p = 0; p < 2; p++) begin
        l_eff = io.orient_horz ? dn[p] : lf[p];
        r_eff = io.orient_horz ? up[p] : rt[p];
        lo[p] = l_eff && !r_eff;
        ro[p] = r_eff && !l_eff;
        if (!io.autofire_en) begin
          fo[p] = fr[p];  m_run[p] = 0;
        end else if (!fr[p]) begin
          fo[p] = 1'b0;   m_run[p] = 0;
        end else begin
          fo[p] = ((m_run[p] / HALF) % 2) == 0;
          m_run[p]++;
        end
      end
      e = {(m_age >= 0) && (m_age < P), st[0], st[1], lo[0], ro[0], fo[0], lo[1], ro[1], fo[1]};
      if (io.ps2_key[64] != m_tgl) begin
        m_tgl = io.ps2_key[64];
        if (io.ps2_key[63:24] == 40'd0) key_st[io.ps2_key[7:0]] = (io.ps2_key[15:8] != 8'hF0);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    logic [8:0] got, exp;
    @(posedge clk_sys);
    model_step();
    #1;
    got = {io.coin, io.start1, io.start2, io.left1, io.right1, io.fire1, io.left2, io.right2, io.fire2};
    exp = exp_q.pop_front();
    check_eq("outs", 32'(got), 32'(exp));
  endtask

  task automatic send_key(input logic [7:0] code, input bit press, input bit ext);
    logic [64:0] k;
    k         = '0;
    k[64]     = ~io.ps2_key[64];
    k[63:24]  = ext ? 40'd1 : 40'd0;
    k[15:8]   = press ? 8'h00 : 8'hF0;
    k[7:0]    = code;
    io.ps2_key = k;
  endtask

  initial begin
    int cnt;
    int starts [$];
    logic prev_c;
    logic [13:0] pat_got;
    logic f1_seen;
    logic [7:0] codes [9];
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h05, 8'h06, 8'h04, 8'h1C};

    reset = 1'b1;
    io.ps2_key = '0;  io.joystick_0 = '0;  io.joystick_1 = '0;
    io.orient_horz = 1'b0;  io.autofire_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_eq("reset_outs", 32'({io.coin, io.fire1, io.fire2, io.left1, io.right1}), 32'd0);

    // Held coin: one pulse of P cycles, then re-press after release
    io.joystick_0[7] = 1'b1;
    step();
    check_eq("coin_start", 32'(io.coin), 32'd1);
    cnt = 1;
    repeat (29) begin step(); cnt += int'(io.coin); end
    check_eq("coin_held_width", cnt, P);
    io.joystick_0[7] = 1'b0;
    repeat (2) step();
    io.joystick_0[7] = 1'b1;
    cnt = 0;
    repeat (12) begin step(); cnt += int'(io.coin); end
    check_eq("coin_repress_width", cnt, P);
    io.joystick_0[7] = 1'b0;
    repeat (12) step();

    // Press inside HOLD is dropped; press after IDLE starts the second pulse
    prev_c = io.coin;
    for (int t = 0; t < 24; t++) begin
      io.joystick_0[7] = (t == 0) || (t == 5) || (t == 12) || (t == 13);
      step();
      if (io.coin && !prev_c) starts.push_back(t + 1);
      prev_c = io.coin;
    end
    check_eq("coin_pulse_count", starts.size(), 2);
    check_eq("coin_first_start", (starts.size() > 0) ? starts[0] : -1, 1);
    check_eq("coin_second_start", (starts.size() > 1) ? starts[1] : -1, 13);
    io.joystick_0[7] = 1'b0;
    repeat (3) step();

    // PS/2 fire key: press, release, and an ignored PrtScr/Pause-class event
    send_key(8'h29, 1'b1, 1'b0);
    step();  step();
    check_eq("key_fire_press", 32'(io.fire1), 32'd1);
    send_key(8'h29, 1'b0, 1'b0);
    step();  step();
    check_eq("key_fire_release", 32'(io.fire1), 32'd0);
    send_key(8'h29, 1'b1, 1'b1);
    step();  step();
    check_eq("key_ext_ignored", 32'(io.fire1), 32'd0);

    // Orientation remap and opposing directions
    io.orient_horz = 1'b1;  io.joystick_0[3] = 1'b1;
    step();
    check_eq("horz_up_right", 32'({io.left1, io.right1}), 32'b01);
    io.joystick_0[2] = 1'b1;
    step();
    check_eq("horz_opposed", 32'({io.left1, io.right1}), 32'b00);
    io.orient_horz = 1'b0;
    step();
    check_eq("vert_no_lr", 32'({io.left1, io.right1}), 32'b00);
    io.joystick_0[3:2] = 2'b00;

    // Autofire on player 2
    io.autofire_en = 1'b1;
    io.joystick_1[4] = 1'b1;
    f1_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      pat_got[i] = io.fire2;
      f1_seen |= io.fire1;
    end
    check_eq("autofire_pattern", 32'(pat_got), 32'(14'b11000111000111));
    check_eq("autofire_p1_idle", 32'(f1_seen), 32'd0);
    io.joystick_1[4] = 1'b0;
    step();
    check_eq("autofire_release", 32'(io.fire2), 32'd0);
    io.autofire_en = 1'b0;
    repeat (12) step();

    // Reset two cycles into a coin pulse with a concurrent key event
    io.joystick_0[7] = 1'b1;
    step();  step();
    reset = 1'b1;
    send_key(8'h29, 1'b1, 1'b0);
    step();
    check_eq("reset_mid_pulse", 32'({io.coin, io.start1, io.start2, io.left1, io.right1,
                                       io.fire1, io.left2, io.right2, io.fire2}), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (16) begin step(); cnt += int'(io.coin) + int'(io.fire1); end
    check_eq("post_reset_quiet", cnt, 0);
    io.joystick_0[7] = 1'b0;
    step();
    io.joystick_0[7] = 1'b1;
    step();
    check_eq("post_reset_new_edge", 32'(io.coin), 32'd1);
    io.joystick_0[7] = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        io.joystick_0[6:0] = 7'($urandom());
        io.joystick_1[6:0] = 7'($urandom());
      end
      if ($urandom_range(0, 15) == 0) io.joystick_0[7] = ~io.joystick_0[7];
      if ($urandom_range(0, 23) == 0) io.joystick_1[7] = ~io.joystick_1[7];
      if ($urandom_range(0, 63) == 0) io.orient_horz = ~io.orient_horz;
      if ($urandom_range(0, 31) == 0) io.autofire_en = ~io.autofire_en;
      if ($urandom_range(0, 9) == 0)
        send_key(codes[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      step();
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
